sample_tick_gen: RTL

//  Timebase engine for the capture path. Maps a front-panel time/div scale code to a sample period in clk cycles.

---
 rtl/sampling_pkg.sv | 13 +
 rtl/scale_period_lut.sv | 13 +
 rtl/sample_tick_gen.sv | 67 ++++++
 3 files changed

// File: rtl/sampling_pkg.sv
// sampling_pkg: timebase states and the time/div scale-to-period table
package sampling_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  localparam int unsigned DEFAULT_PERIOD = 10_000_000;
  localparam int unsigned PERIOD_TABLE [16] = '{
    100, 200, 400, 1_000, 2_000, 4_000, 10_000, 20_000,
    40_000, 100_000, 200_000, 400_000, 1_000_000, 2_000_000, 4_000_000, 10_000_000
  };
  // Codes outside 1..16 fall back to the slowest timebase
  function automatic int unsigned scale_to_period(input int unsigned code);
    return (code >= 1 && code <= 16) ? PERIOD_TABLE[4'(code - 1)] : DEFAULT_PERIOD;
  endfunction
endpackage

// File: rtl/scale_period_lut.sv
// scale_period_lut: combinational time/div code to sample period in clk cycles
module scale_period_lut
  import sampling_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SCALE_W     = 5,
  parameter int PERIOD_MULT = 1
) (
  input  logic [SCALE_W-1:0] i_code,
  output logic [CNT_W-1:0]   o_period
);
  assign o_period = CNT_W'(scale_to_period(32'(i_code))) * CNT_W'(PERIOD_MULT);
endmodule

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: arm/trigger timebase emitting one sample strobe per period for one frame
module sample_tick_gen
  import sampling_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SCALE_W     = 5,
  parameter int PERIOD_MULT = 1,
  parameter int FRAME_LEN   = 1000,
  parameter int IDX_W       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic               continuous,
  input  logic               arm,
  input  logic               trig,
  input  logic               abort,
  output logic               sample_tick,
  output logic [IDX_W-1:0]   sample_idx,
  output logic               frame_done,
  output logic               busy,
  output logic [CNT_W-1:0]   period_out
);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD) * CNT_W'(PERIOD_MULT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_period;
  logic [IDX_W-1:0] w_nidx;
  logic w_fire, w_end;
  scale_period_lut #(.CNT_W(CNT_W), .SCALE_W(SCALE_W), .PERIOD_MULT(PERIOD_MULT)) u_lut (
    .i_code  (scale_in),
    .o_period(w_period)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (abort)                        w_next = IDLE;
    else if (w_end)                   w_next = continuous ? ARMED : IDLE;
    else if (r_state == IDLE && arm)  w_next = ARMED;
    else if (w_fire)                  w_next = RUN;
  end
  // The trigger strobe is index 0; each period wrap in RUN advances the index
  always_comb begin
    w_nidx = (r_state == RUN) ? sample_idx + IDX_W'(1) : '0;
    w_fire = !abort && ((r_state == ARMED && trig) ||
                        (r_state == RUN && r_cnt == period_out - CNT_W'(1)));
    w_end  = w_fire && w_nidx == LAST_IDX;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sample_tick <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      sample_idx  <= '0;
      r_cnt       <= '0;
      period_out  <= RST_PERIOD;
    end else begin
      sample_tick <= w_fire;
      frame_done  <= w_end;
      busy        <= r_state != IDLE;
      r_cnt       <= (w_fire || r_state != RUN) ? '0 : r_cnt + CNT_W'(1);
      if (w_fire) sample_idx <= w_nidx;
      if (w_next == ARMED && (r_state == IDLE || w_end)) period_out <= w_period;
    end
endmodule
